// File: rtl/window_sum_pkg.sv
// Shared types and helpers for the multi-channel window rectangle-sum block.
//
// Contents:
//   fsm_state_e  - row phase of the window (first row / middle rows / last row)
//   corner_op_e  - what a lane does with the current sample (nothing, add, subtract)
//   fsm_dbg_t    - snapshot of the control path, exposed for bound checkers
//   cnt_width()  - counter width for a count range 0..n-1, at least 1 bit
package window_sum_pkg;

    typedef enum logic [1:0] {
        S_FIRST = 2'd0,
        S_MID   = 2'd1,
        S_LAST  = 2'd2
    } fsm_state_e;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2
    } corner_op_e;

    typedef struct packed {
        fsm_state_e state;
        logic       accept;
        logic       final_beat;
        corner_op_e op;
    } fsm_dbg_t;

    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/window_sum_lane.sv
// One channel of the window rectangle sum.
//
// The lane keeps a running accumulator of the corner terms seen so far in the
// current window and an output register that holds the finished sum.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   en        - an input beat is accepted this cycle
//   op        - corner operation for this beat (none / add / subtract)
//   clr       - discard the accumulator after this beat (no output update)
//   last      - final beat: accumulator + this term goes to sum, accumulator clears
//   sample    - unsigned integral-image sample for this channel
//   sum       - registered window sum, two's complement, W_DATA+2 bits
module window_sum_lane
    import window_sum_pkg::*;
#(
    parameter int W_DATA = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  corner_op_e        op,
    input  logic              clr,
    input  logic              last,
    input  logic [W_DATA-1:0] sample,
    output logic [W_DATA+1:0] sum
);

    localparam int DW = W_DATA + 2;

    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] sum_q, sum_d;
    logic [DW-1:0] ext;
    logic [DW-1:0] term;

    always_comb begin
        // Samples are non-negative integral-image values, so zero-extend.
        ext = {2'b00, sample};
        case (op)
            OP_ADD:  term = ext;
            OP_SUB:  term = -ext;
            default: term = '0;
        endcase

        acc_d = acc_q;
        sum_d = sum_q;
        if (en) begin
            if (clr) begin
                acc_d = '0;
            end else if (last) begin
                sum_d = acc_q + term;
                acc_d = '0;
            end else begin
                acc_d = acc_q + term;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            sum_q <= '0;
        end else begin
            acc_q <= acc_d;
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/window_sum_mc.sv
// Multi-channel window rectangle sum: D - B - C + A per channel, where A, B, C, D
// are the top-left, top-right, bottom-left and bottom-right samples of a
// WIN_H x WIN_W window streamed row-major. All channels share one handshake.
//
// Optional build macro: WINDOW_SUM_PROTO_CHECK_EN
//   When defined, din_eot is compared against the counter position on every
//   accepted beat; a mismatch sets the sticky err flag, drops the current
//   window and resynchronises the counters to the eot markers.
//   When undefined, din_eot is ignored and err is tied low.
//
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   din_valid   - input beat valid
//   din_ready   - input beat accepted when din_valid & din_ready
//   din_data    - N_CH samples, channel c at [c*W_DATA +: W_DATA]
//   din_eot     - [0] last beat of row, [1] last beat of window
//   dout_valid  - window sums valid, held with dout_data until dout_ready
//   dout_ready  - downstream accepts
//   dout_data   - N_CH sums, channel c at [c*(W_DATA+2) +: W_DATA+2]
//   err         - sticky protocol error
//
// Handshake: a beat transfers on any clock edge where valid and ready are both
// high. The producer holds data stable while valid is high and ready is low.
// din_ready = !dout_valid | dout_ready, so a new window's first beat can enter
// in the same cycle the previous result is consumed.
module window_sum_mc
    import window_sum_pkg::*;
#(
    parameter int W_DATA = 26,
    parameter int N_CH   = 2,
    parameter int WIN_H  = 24,
    parameter int WIN_W  = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       din_valid,
    output logic                       din_ready,
    input  logic [N_CH*W_DATA-1:0]     din_data,
    input  logic [1:0]                 din_eot,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [N_CH*(W_DATA+2)-1:0] dout_data,
    output logic                       err
);

    localparam int DW = W_DATA + 2;
    localparam int CW = cnt_width(WIN_W);
    localparam int RW = cnt_width(WIN_H);
    localparam logic [CW-1:0] COL_LAST    = CW'(WIN_W - 1);
    localparam logic [RW-1:0] ROW_LAST    = RW'(WIN_H - 1);
    localparam logic [RW-1:0] ROW_PRELAST = RW'(WIN_H - 2);

    fsm_state_e      state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            dout_valid_q, dout_valid_d;

    logic            accept;
    logic            col_first;
    logic            col_last;
    logic            row_last;
    logic            final_beat;
    corner_op_e      op;
    logic            lane_clr;
    logic            lane_last;
    logic            proto_err;

`ifdef WINDOW_SUM_PROTO_CHECK_EN
    logic            err_q, err_d;
    // Set after a mismatch that leaves the counters mid-window; the rest of
    // that window is consumed without producing a result.
    logic            drop_q, drop_d;
    logic [1:0]      exp_eot;
`endif

    // ---------------- output / decode logic ----------------
    always_comb begin
        din_ready  = !rst && (!dout_valid_q || dout_ready);
        accept     = din_valid && din_ready;
        col_first  = (col_q == '0);
        col_last   = (col_q == COL_LAST);
        row_last   = (row_q == ROW_LAST);
        final_beat = (state_q == S_LAST) && col_last;

        op = OP_NONE;
        case (state_q)
            S_FIRST: begin
                if (col_first)     op = OP_ADD;
                else if (col_last) op = OP_SUB;
            end
            S_LAST: begin
                if (col_first)     op = OP_SUB;
                else if (col_last) op = OP_ADD;
            end
            default: op = OP_NONE;
        endcase

`ifdef WINDOW_SUM_PROTO_CHECK_EN
        exp_eot   = {col_last && row_last, col_last};
        proto_err = accept && (din_eot != exp_eot);
        lane_clr  = proto_err || (final_beat && drop_q);
        lane_last = final_beat && !proto_err && !drop_q;
`else
        proto_err = 1'b0;
        lane_clr  = 1'b0;
        lane_last = final_beat;
`endif
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        state_d      = state_q;
        dout_valid_d = dout_valid_q;

        if (dout_ready)            dout_valid_d = 1'b0;
        if (accept && lane_last)   dout_valid_d = 1'b1;

        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            case (state_q)
                S_FIRST: if (col_last) state_d = (WIN_H == 2) ? S_LAST : S_MID;
                S_MID:   if (col_last && row_q == ROW_PRELAST) state_d = S_LAST;
                S_LAST:  if (col_last) state_d = S_FIRST;
                default: state_d = S_FIRST;
            endcase
        end

`ifdef WINDOW_SUM_PROTO_CHECK_EN
        err_d  = err_q || proto_err;
        drop_d = drop_q;
        if (accept) begin
            if (proto_err) begin
                // Follow the markers: window end restarts, row end skips to
                // the next row, otherwise keep counting.
                if (din_eot[1]) begin
                    col_d = '0;
                    row_d = '0;
                end else if (din_eot[0]) begin
                    col_d = '0;
                    row_d = row_last ? '0 : row_q + 1'b1;
                end
                state_d = (row_d == '0)      ? S_FIRST :
                          (row_d == ROW_LAST) ? S_LAST  : S_MID;
                drop_d  = !((col_d == '0) && (row_d == '0));
            end else if (final_beat) begin
                drop_d = 1'b0;
            end
        end
`endif
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FIRST;
            col_q        <= '0;
            row_q        <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            dout_valid_q <= dout_valid_d;
        end
    end

`ifdef WINDOW_SUM_PROTO_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q  <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            err_q  <= err_d;
            drop_q <= drop_d;
        end
    end

    assign err = err_q;
`else
    logic unused_eot;
    assign unused_eot = ^din_eot;
    assign err        = 1'b0;
`endif

    assign dout_valid = dout_valid_q;

    // Observation point for bound checkers; not consumed by the datapath.
    fsm_dbg_t dbg_unused;
    assign dbg_unused = '{state: state_q, accept: accept, final_beat: final_beat, op: op};

    // ---------------- per-channel lanes ----------------
    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        window_sum_lane #(
            .W_DATA (W_DATA)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .en     (accept),
            .op     (op),
            .clr    (lane_clr),
            .last   (lane_last),
            .sample (din_data[g*W_DATA +: W_DATA]),
            .sum    (dout_data[g*DW +: DW])
        );
    end

endmodule

// File: tb/tb_window_sum_mc.sv
module tb_window_sum_mc;

  localparam int W_DATA = 26;
  localparam int N_CH   = 2;
  localparam int WIN_H  = 3;
  localparam int WIN_W  = 3;
  localparam int DW     = W_DATA + 2;
  localparam int OUT_W  = N_CH * DW;
  localparam int NB     = WIN_H * WIN_W;
`ifdef WINDOW_SUM_PROTO_CHECK_EN
  localparam logic PROTO = 1'b1;
`else
  localparam logic PROTO = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   din_valid;
  logic                   din_ready;
  logic [N_CH*W_DATA-1:0] din_data;
  logic [1:0]             din_eot;
  logic                   dout_valid;
  logic                   dout_ready;
  logic [OUT_W-1:0]       dout_data;
  logic                   err;

  int checks  = 0;
  int errors  = 0;
  int in_cnt  = 0;
  int out_cnt = 0;
  int rdy_mode = 0;  // 0: ready high, 1: random, 2: driven by the running test

  logic [OUT_W-1:0]  exp_q[$];
  logic [OUT_W-1:0]  mon_exp;
  logic [W_DATA-1:0] win [N_CH][NB];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  window_sum_mc #(
    .W_DATA (W_DATA),
    .N_CH   (N_CH),
    .WIN_H  (WIN_H),
    .WIN_W  (WIN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_data   (din_data),
    .din_eot    (din_eot),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .err        (err)
  );

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) dout_ready = 1'b1;
    else if (rdy_mode == 1) dout_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      checks++;
      out_cnt++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %h, required no output", dout_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (dout_data !== mon_exp) begin
          errors++;
          $display("FAIL window_sum: got %h, required %h", dout_data, mon_exp);
        end
      end
    end
  end

  // ---------------- model / stimulus helpers ----------------
  task automatic fill_window();
    for (int ch = 0; ch < N_CH; ch++)
      for (int b = 0; b < NB; b++)
        win[ch][b] = W_DATA'($urandom());
  endtask

  task automatic set_corners(input int ch, input logic [W_DATA-1:0] a, input logic [W_DATA-1:0] b,
                             input logic [W_DATA-1:0] c, input logic [W_DATA-1:0] d);
    win[ch][0]          = a;
    win[ch][WIN_W-1]    = b;
    win[ch][NB-WIN_W]   = c;
    win[ch][NB-1]       = d;
  endtask

  function automatic logic [OUT_W-1:0] model_out();
    logic [OUT_W-1:0] r;
    logic [DW-1:0]    s;
    r = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      s = DW'(win[ch][NB-1]) - DW'(win[ch][WIN_W-1]) - DW'(win[ch][NB-WIN_W]) + DW'(win[ch][0]);
      r[ch*DW +: DW] = s;
    end
    return r;
  endfunction

  task automatic push_expected();
    exp_q.push_back(model_out());
    in_cnt++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [N_CH*W_DATA-1:0] d, input logic [1:0] e, input bit gaps);
    int n;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        din_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    din_valid = 1'b1;
    din_data  = d;
    din_eot   = e;
    n = 0;
    @(negedge clk);
    while (!din_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!din_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout: din_ready=%b after %0d cycles, required 1", din_ready, n);
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic drive_range(input int lo, input int hi, input int bad_idx, input bit gaps);
    logic [N_CH*W_DATA-1:0] d;
    logic [1:0]             e;
    for (int b = lo; b < hi; b++) begin
      for (int ch = 0; ch < N_CH; ch++) d[ch*W_DATA +: W_DATA] = win[ch][b];
      e[0] = ((b % WIN_W) == WIN_W - 1);
      e[1] = ((b % WIN_W) == WIN_W - 1) && ((b / WIN_W) == WIN_H - 1);
      if (b == bad_idx) e = 2'b11;
      drive_beat(d, e, gaps);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results pending, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst       = 1'b1;
    din_valid = 1'b0;
    din_data  = '0;
    din_eot   = 2'b00;
    rdy_mode  = 0;
    dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL reset_din_ready: got %b, required 0", din_ready); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %b, required 0", dout_valid); end
    checks++; if (dout_data !== '0) begin errors++; $display("FAIL reset_dout_data: got %h, required 0", dout_data); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", err); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL post_reset_din_ready: got %b, required 1", din_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    for (int rep = 0; rep < 2; rep++) begin
      fill_window();
      set_corners(0, 26'd10, 26'd40, 26'd70, 26'd200);
      push_expected();
      drive_range(0, NB - 1, -1, 1'b0);
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL latency_early: dout_valid=%b, required 0", dout_valid); end
      drive_range(NB - 1, NB, -1, 1'b0);
      checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL latency: dout_valid=%b, required 1", dout_valid); end
      checks++; if (dout_data[DW-1:0] !== 28'd100) begin errors++; $display("FAIL single_ch0: got %0d, required 100", dout_data[DW-1:0]); end
      wait_drain();
    end
  endtask

  task automatic test_two_ch();
    fill_window();
    set_corners(0, 26'd10, 26'd40, 26'd70, 26'd200);
    set_corners(1, 26'd1, 26'd4, 26'd9, 26'd400);
    push_expected();
    drive_range(0, NB, -1, 1'b0);
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL two_ch_valid: got %b, required 1", dout_valid); end
    checks++; if (dout_data !== {28'd388, 28'd100}) begin errors++; $display("FAIL two_ch_sum: got %h, required %h", dout_data, {28'd388, 28'd100}); end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int out_before;
    out_before = out_cnt;
    rdy_mode   = 2;
    dout_ready = 1'b0;
    fill_window();
    push_expected();
    drive_range(0, NB, -1, 1'b0);
    fill_window();
    push_expected();
    fork
      drive_range(0, NB, -1, 1'b0);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL hold_din_ready: cycle %0d got %b, required 0", i, din_ready); end
          checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL hold_dout_valid: cycle %0d got %b, required 1", i, dout_valid); end
          checks++; if (dout_data !== exp_q[0]) begin errors++; $display("FAIL hold_dout_data: cycle %0d got %h, required %h", i, dout_data, exp_q[0]); end
        end
        @(posedge clk);
        #1;
        rdy_mode   = 0;
        dout_ready = 1'b1;
      end
    join
    wait_drain();
    checks++; if (out_cnt - out_before !== 2) begin errors++; $display("FAIL b2b_count: got %0d windows, required 2", out_cnt - out_before); end
  endtask

  task automatic test_random();
    rdy_mode = 1;
    for (int w = 0; w < 6; w++) begin
      fill_window();
      push_expected();
      drive_range(0, NB, -1, 1'b1);
    end
    rdy_mode = 0;
    wait_drain();
    checks++; if (out_cnt !== in_cnt) begin errors++; $display("FAIL random_count: got %0d windows out, required %0d", out_cnt, in_cnt); end
  endtask

  task automatic test_reset_mid();
    fill_window();
    drive_range(0, 5, -1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_din_ready: got %b, required 0", din_ready); end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_dout_valid: got %b, required 0", dout_valid); end
    @(posedge clk);
    #1;
    fill_window();
    push_expected();
    drive_range(0, NB, -1, 1'b0);
    wait_drain();
  endtask

  task automatic test_proto();
    fill_window();
`ifdef WINDOW_SUM_PROTO_CHECK_EN
    drive_range(0, 7, 6, 1'b0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL proto_err_set: got %b, required 1", err); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL proto_drop: cycle %0d dout_valid=%b, required 0", i, dout_valid); end
    end
    @(posedge clk);
    #1;
`else
    push_expected();
    drive_range(0, NB, 6, 1'b0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL proto_err_base: got %b, required 0", err); end
`endif
    wait_drain();
    fill_window();
    push_expected();
    drive_range(0, NB, -1, 1'b0);
    wait_drain();
    checks++; if (err !== PROTO) begin errors++; $display("FAIL proto_err_sticky: got %b, required %b", err, PROTO); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single();
    test_two_ch();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_proto();
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
